seg_memory: RTL and testbench

SEG_MEMORY -- requirements
Module: seg_memory

---
 rtl/seg_memory.sv | 76 +++++++
 tb/tb_seg_memory.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg_memory.sv
// MEM pipeline stage: word-addressed data memory with MEM/WB output registers,
// branch resolution and a combinational debug read port.
module seg_memory #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_DEPTH   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LEN-1:0]        i_ALU_result,
  input  logic [LEN-1:0]        i_write_data,
  input  logic [NB_ADDR-1:0]    i_write_register,
  input  logic                  i_ALU_zero,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic                  i_stall,
  input  logic [NB_DEPTH-1:0]   i_dbg_addr,
  output logic [LEN-1:0]        o_read_data,
  output logic [LEN-1:0]        o_ALU_result,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic                  o_PCSrc,
  output logic [LEN-1:0]        o_dbg_data
);
  localparam int DEPTH = 1 << NB_DEPTH;

  logic [LEN-1:0]        mem_q [DEPTH];
  logic [LEN-1:0]        read_data_q, read_data_d;
  logic [LEN-1:0]        alu_q;
  logic [NB_ADDR-1:0]    wreg_q;
  logic [NB_CTRL_WB-1:0] wb_q;

  logic [NB_DEPTH-1:0] idx;
  logic                branch, mem_read, mem_write;

  // Byte address -> word index; upper bits drop so accesses wrap.
  assign idx       = i_ALU_result[NB_DEPTH+1:2];
  assign branch    = i_ctrl_mem_bus[2];
  assign mem_read  = i_ctrl_mem_bus[1];
  assign mem_write = i_ctrl_mem_bus[0];

  assign o_PCSrc     = branch & i_ALU_zero;
  assign o_dbg_data  = mem_q[i_dbg_addr];

  // Sampled from the pre-edge array, so a combined read+write returns old data.
  assign read_data_d = mem_read ? mem_q[idx] : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!i_stall && mem_write) begin
      mem_q[idx] <= i_write_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      read_data_q <= '0;
      alu_q       <= '0;
      wreg_q      <= '0;
      wb_q        <= '0;
    end else if (!i_stall) begin
      read_data_q <= read_data_d;
      alu_q       <= i_ALU_result;
      wreg_q      <= i_write_register;
      wb_q        <= i_ctrl_wb_bus;
    end
  end

  assign o_read_data      = read_data_q;
  assign o_ALU_result     = alu_q;
  assign o_write_register = wreg_q;
  assign o_ctrl_wb_bus    = wb_q;
endmodule

// File: tb/tb_seg_memory.sv
// Randomized + directed bench for seg_memory against a behavioural memory model.
module tb_seg_memory;
  logic        clk, rst_n;
  logic [31:0] alu_i, wd_i;
  logic [4:0]  wreg_i;
  logic        zero_i;
  logic [1:0]  wb_i;
  logic [2:0]  m_i;
  logic        stall_i;
  logic [4:0]  dbg_i;
  logic [31:0] rd_o, alu_o, dbg_o;
  logic [4:0]  wreg_o;
  logic [1:0]  wb_o;
  logic        pcsrc_o;

  seg_memory dut (
    .i_clk(clk), .i_rst(rst_n), .i_ALU_result(alu_i), .i_write_data(wd_i),
    .i_write_register(wreg_i), .i_ALU_zero(zero_i), .i_ctrl_wb_bus(wb_i),
    .i_ctrl_mem_bus(m_i), .i_stall(stall_i), .i_dbg_addr(dbg_i),
    .o_read_data(rd_o), .o_ALU_result(alu_o), .o_write_register(wreg_o),
    .o_ctrl_wb_bus(wb_o), .o_PCSrc(pcsrc_o), .o_dbg_data(dbg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference state: memory words plus what the MEM/WB outputs should show.
  logic [31:0] mdl_mem [32];
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_wreg;
  logic [1:0]  exp_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("read_data", rd_o, exp_rd);
    chk("alu_result", alu_o, exp_alu);
    chk("write_register", {27'd0, wreg_o}, {27'd0, exp_wreg});
    chk("ctrl_wb", {30'd0, wb_o}, {30'd0, exp_wb});
    chk("dbg_data", dbg_o, mdl_mem[dbg_i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    exp_rd = '0; exp_alu = '0; exp_wreg = '0; exp_wb = '0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model at the edge.
  task automatic step(input logic [31:0] alu, input logic [31:0] wd, input logic [2:0] m,
                      input logic st, input logic z);
    int w;
    alu_i = alu; wd_i = wd; m_i = m; stall_i = st; zero_i = z;
    wreg_i = 5'($urandom); wb_i = 2'($urandom); dbg_i = 5'($urandom);
    #1;
    chk("pcsrc", {31'd0, pcsrc_o}, {31'd0, m[2] && z});
    chk("dbg_pre", dbg_o, mdl_mem[dbg_i]);
    w = (alu / 4) % 32;
    if (!st) begin
      exp_rd   = m[1] ? mdl_mem[w] : 32'd0;
      exp_alu  = alu;
      exp_wreg = wreg_i;
      exp_wb   = wb_i;
      if (m[0]) mdl_mem[w] = wd;
    end
    @(posedge clk); #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] lit);
    dbg_i = a; #1;
    chk(name, dbg_o, lit);
  endtask

  initial begin
    rst_n = 1'b0; alu_i = '0; wd_i = '0; wreg_i = '0; zero_i = 1'b0;
    wb_i = '0; m_i = '0; stall_i = 1'b0; dbg_i = '0;
    model_reset();
    #12;
    compare_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Store then load with ignored low address bits.
    step(32'h8, 32'hDEADBEEF, 3'b001, 1'b0, 1'b0);
    step(32'hB, 32'h0, 3'b010, 1'b0, 1'b0);
    chk("load_lit", rd_o, 32'hDEADBEEF);
    peek("dbg_idx2_lit", 5'd2, 32'hDEADBEEF);

    // Address wrap.
    step(32'h80, 32'h12345678, 3'b001, 1'b0, 1'b0);
    peek("wrap_lit", 5'd0, 32'h12345678);

    // Stall blocks the store and holds outputs, release lets it land.
    step(32'h4, 32'hA5A5A5A5, 3'b001, 1'b1, 1'b0);
    peek("stall_word1_lit", 5'd1, 32'h0);
    chk("stall_hold_alu_lit", alu_o, 32'h80);
    step(32'h4, 32'hA5A5A5A5, 3'b001, 1'b0, 1'b0);
    peek("release_word1_lit", 5'd1, 32'hA5A5A5A5);

    // Branch decision is combinational and ignores stall.
    m_i = 3'b100; zero_i = 1'b1; stall_i = 1'b1; #1; chk("br_taken_lit", {31'd0, pcsrc_o}, 32'd1);
    zero_i = 1'b0; #1; chk("br_zero0_lit", {31'd0, pcsrc_o}, 32'd0);
    m_i = 3'b000; zero_i = 1'b1; #1; chk("br_off_lit", {31'd0, pcsrc_o}, 32'd0);
    stall_i = 1'b0;
    @(negedge clk);

    // Combined read+write returns the old word.
    step(32'hC, 32'h11, 3'b001, 1'b0, 1'b0);
    step(32'hC, 32'h22, 3'b011, 1'b0, 1'b1);
    chk("rmw_old_lit", rd_o, 32'h11);
    peek("rmw_new_lit", 5'd3, 32'h22);

    // Random traffic, addresses mostly in-range with some wrapping.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFF);
      step(a, $urandom, 3'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
    end

    // Asynchronous reset mid-cycle clears outputs and the whole memory at once.
    step(32'h10, 32'hCAFEF00D, 3'b011, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    model_reset();
    chk("rst_read_data", rd_o, 32'h0);
    chk("rst_alu", alu_o, 32'h0);
    chk("rst_wreg", {27'd0, wreg_o}, 32'h0);
    chk("rst_wb", {30'd0, wb_o}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_i = 5'(i); #0.1;
      chk("rst_dbg", dbg_o, 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    step(32'h14, 32'h0BADCAFE, 3'b001, 1'b0, 1'b0);
    peek("post_rst_store_lit", 5'd5, 32'h0BADCAFE);
    step(32'h14, 32'h0, 3'b010, 1'b0, 1'b0);
    chk("post_rst_load_lit", rd_o, 32'h0BADCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
